// File: rtl/scsi_data_buffer_pkg.sv
// Shared definitions for the SCSI data buffer: handshake FSM states and default geometry.
// Pure declarations, no logic; imported by the interface, FIFO and top.
package scsi_bus_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_e;

endpackage

// File: rtl/scsi_data_buffer_if.sv
// Push/pop view of the buffer storage; master is the controller, slave is the FIFO.
// Combinational bundle only; push while full / pop while empty are absorbed by the FIFO.
interface scsi_data_buffer_if
    import scsi_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int LW = $clog2(DEPTH) + 1;

    logic             push_vld;
    logic [WIDTH-1:0] push_dat;
    logic             pop_vld;
    logic [WIDTH-1:0] head_dat;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;

    modport master (
        output push_vld, push_dat, pop_vld,
        input  head_dat, full, empty, level
    );

    modport slave (
        input  push_vld, push_dat, pop_vld,
        output head_dat, full, empty, level
    );

endinterface

// File: rtl/scsi_data_buffer_fifo.sv
// First-word-fall-through FIFO; head visible combinationally, level updates one edge after push/pop.
// Push while full and pop while empty are silently ignored; flush clears pointers synchronously.
module scsi_fifo
    import scsi_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    scsi_data_buffer_if.slave fif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             wr_en;
    logic             rd_en;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_en  = fif.push_vld && (cnt_q != LW'(DEPTH));
        rd_en  = fif.pop_vld && (cnt_q != '0);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + 1'b1;
            if (rd_en) rptr_d = rptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !flush) begin
            mem_q[wptr_q] <= fif.push_dat;
        end
    end

    assign fif.head_dat = mem_q[rptr_q];
    assign fif.full     = (cnt_q == LW'(DEPTH));
    assign fif.empty    = (cnt_q == '0);
    assign fif.level    = cnt_q;

endmodule

// File: rtl/scsi_data_buffer.sv
// SCSI byte buffer: FIFO plus four-phase req/ack bus FSM with active-low data; optional parity via SCSI_PARITY_EN.
// Mode 0 drives data one cycle before extReq; mode 1 captures on first extAck high; FSM stalls on empty/full.
module scsi_data_buffer
    import scsi_bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       intData,
    input  logic                   intWrite,
    input  logic                   intRead,
    output logic [WIDTH-1:0]       intDataOut,
    output logic                   intFull,
    output logic                   intEmpty,
    output logic [$clog2(DEPTH):0] fillLevel,
    output logic                   overflow,
    input  logic [WIDTH-1:0]       extDataIn,
    output logic [WIDTH-1:0]       extDataOut,
    output logic                   extOE,
    output logic                   extReq,
    input  logic                   extAck,
    output logic                   extParityOut,
    output logic                   parityError
);

    bus_state_e state_q, state_d;
    logic       dir_q, dir_d;
    logic       overflow_q, overflow_d;
    logic       eff_mode;
    logic       oe;
    logic       req;
    logic       ext_push;
    logic       ext_pop;

    scsi_data_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_bus ();

    scsi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .fif   (fifo_bus)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        oe       = 1'b0;
        req      = 1'b0;
        ext_push = 1'b0;
        ext_pop  = 1'b0;
        case (state_q)
            // Direction is latched here and held until the handshake returns to IDLE.
            ST_IDLE: begin
                dir_d = mode;
                if (!mode && !fifo_bus.empty) begin
                    state_d = ST_SETUP;
                end else if (mode && !fifo_bus.full) begin
                    state_d = ST_REQ;
                end
            end
            ST_SETUP: begin
                oe      = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req = 1'b1;
                oe  = !dir_q;
                if (extAck) begin
                    ext_pop  = !dir_q;
                    ext_push = dir_q;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                oe = !dir_q;
                if (!extAck) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // Outside IDLE the latched direction decides which side owns push and pop.
    assign eff_mode = (state_q == ST_IDLE) ? mode : dir_q;

    always_comb begin
        fifo_bus.push_vld = eff_mode ? ext_push : intWrite;
        fifo_bus.push_dat = eff_mode ? ~extDataIn : intData;
        fifo_bus.pop_vld  = eff_mode ? intRead : ext_pop;
    end

    assign overflow_d = flush ? 1'b0 : (overflow_q | (fifo_bus.push_vld & fifo_bus.full));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SCSI_PARITY_EN
    logic perr_q, perr_d;
    logic [WIDTH-1:0] cap_word;

    // Captured word must carry an odd number of ones; the word is kept either way.
    assign cap_word = ~extDataIn;
    assign perr_d   = flush ? 1'b0 : (perr_q | (ext_push & ~(^cap_word)));

    always_ff @(posedge clock) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign extParityOut = oe ? (^fifo_bus.head_dat) : 1'b0;
    assign parityError  = perr_q;
`else
    assign extParityOut = 1'b0;
    assign parityError  = 1'b0;
`endif

    assign intDataOut = (eff_mode && !fifo_bus.empty) ? fifo_bus.head_dat : '0;
    assign intFull    = fifo_bus.full;
    assign intEmpty   = fifo_bus.empty;
    assign fillLevel  = fifo_bus.level;
    assign overflow   = overflow_q;
    assign extDataOut = oe ? ~fifo_bus.head_dat : '0;
    assign extOE      = oe;
    assign extReq     = req;

endmodule
